input_pixel_queue: RTL

Input-layer front end that loads a binarized image serially, records the index of every set pixel in a FIFO, and presents that FIFO to the Layer 1 controller through its `inputsReady` / `queueEmpty` / `dequeue` / `queueOut` interface. It is the producer end of the Layer 1 pixel queue. It holds one image at a time and refuses new pixels until Layer 1 has drained the queue and had time to finish.

---
 rtl/input_pixel_queue_if.sv | 24 ++
 rtl/input_pixel_queue.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/input_pixel_queue_if.sv
// Pixel load and Layer 1 queue handshake between the input front end and its neighbours.
interface input_pixel_queue_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  pixelIn;
  logic                  pixelValid;
  logic                  dequeue;
  logic                  loadReady;
  logic                  inputsReady;
  logic                  queueEmpty;
  logic                  emptyImage;
  logic [ADDR_WIDTH-1:0] queueOut;
  logic [ADDR_WIDTH:0]   queueCount;

  modport master (
    output pixelIn, pixelValid, dequeue,
    input  loadReady, inputsReady, queueEmpty, emptyImage, queueOut, queueCount
  );

  modport slave (
    input  pixelIn, pixelValid, dequeue,
    output loadReady, inputsReady, queueEmpty, emptyImage, queueOut, queueCount
  );
endinterface

// File: rtl/input_pixel_queue.sv
// Serial image loader that queues the indices of set pixels for the Layer 1 controller.
module input_pixel_queue #(
  parameter int PIXELS      = 784,
  parameter int ADDR_WIDTH  = 10,
  parameter int HOLD_CYCLES = 4
) (
  input logic                clk,
  input logic                reset,
  input_pixel_queue_if.slave bus
);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_PIXEL = ADDR_WIDTH'(PIXELS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1'b1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH + 1)'(1'b1);
  localparam logic [HOLD_W-1:0]     HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0]     HOLD_ONE   = HOLD_W'(1'b1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SERVE = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] mem_r [PIXELS];
  logic [ADDR_WIDTH-1:0] pixCnt_r;
  logic [ADDR_WIDTH-1:0] wrPtr_r;
  logic [ADDR_WIDTH-1:0] rdPtr_r;
  logic [ADDR_WIDTH-1:0] queueOut_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic [HOLD_W-1:0]     holdCnt_r;
  logic                  loadReady_r;
  logic                  inputsReady_r;
  logic                  queueEmpty_r;
  logic                  emptyImage_r;

  logic                  accept_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  last_s;
  logic [ADDR_WIDTH:0]   countAfterPush_s;
  logic [ADDR_WIDTH-1:0] rdNext_s;

  // Decode this cycle's accept/push/pop from state and inputs
  always_comb begin
    accept_s         = (state_r == LOAD) && bus.pixelValid;
    push_s           = accept_s && bus.pixelIn;
    pop_s            = (state_r == SERVE) && bus.dequeue && (count_r != '0);
    last_s           = accept_s && (pixCnt_r == LAST_PIXEL);
    countAfterPush_s = count_r + {{ADDR_WIDTH{1'b0}}, push_s};
    rdNext_s         = rdPtr_r + ADDR_ONE;
  end

  // Queue storage; writes happen only in LOAD so they never race a pop
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wrPtr_r] <= pixCnt_r;
    end
  end

  // Load / serve / hold sequencing with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= LOAD;
      pixCnt_r      <= '0;
      wrPtr_r       <= '0;
      rdPtr_r       <= '0;
      count_r       <= '0;
      holdCnt_r     <= '0;
      queueOut_r    <= '0;
      loadReady_r   <= 1'b1;
      inputsReady_r <= 1'b0;
      queueEmpty_r  <= 1'b1;
      emptyImage_r  <= 1'b0;
    end else begin
      emptyImage_r <= 1'b0;
      case (state_r)
        LOAD: begin
          if (accept_s) begin
            count_r      <= countAfterPush_s;
            queueEmpty_r <= (countAfterPush_s == '0);
            if (push_s) begin
              wrPtr_r <= wrPtr_r + ADDR_ONE;
              // Show-ahead head: the first push of an image becomes the head directly
              if (count_r == '0) begin
                queueOut_r <= pixCnt_r;
              end
            end
            if (last_s) begin
              pixCnt_r <= '0;
              if (countAfterPush_s != '0) begin
                state_r       <= SERVE;
                loadReady_r   <= 1'b0;
                inputsReady_r <= 1'b1;
              end else begin
                emptyImage_r <= 1'b1;
                wrPtr_r      <= '0;
                rdPtr_r      <= '0;
              end
            end else begin
              pixCnt_r <= pixCnt_r + ADDR_ONE;
            end
          end
        end
        SERVE: begin
          if (pop_s) begin
            rdPtr_r <= rdNext_s;
            count_r <= count_r - CNT_ONE;
            if (count_r == CNT_ONE) begin
              state_r       <= HOLD;
              holdCnt_r     <= '0;
              inputsReady_r <= 1'b0;
              queueEmpty_r  <= 1'b1;
              queueOut_r    <= '0;
            end else begin
              queueOut_r <= mem_r[rdNext_s];
            end
          end
        end
        HOLD: begin
          if (holdCnt_r == HOLD_LAST) begin
            state_r     <= LOAD;
            loadReady_r <= 1'b1;
            holdCnt_r   <= '0;
            pixCnt_r    <= '0;
            wrPtr_r     <= '0;
            rdPtr_r     <= '0;
          end else begin
            holdCnt_r <= holdCnt_r + HOLD_ONE;
          end
        end
        default: begin
          state_r       <= LOAD;
          pixCnt_r      <= '0;
          wrPtr_r       <= '0;
          rdPtr_r       <= '0;
          count_r       <= '0;
          holdCnt_r     <= '0;
          queueOut_r    <= '0;
          loadReady_r   <= 1'b1;
          inputsReady_r <= 1'b0;
          queueEmpty_r  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.loadReady   = loadReady_r;
  assign bus.inputsReady = inputsReady_r;
  assign bus.queueEmpty  = queueEmpty_r;
  assign bus.emptyImage  = emptyImage_r;
  assign bus.queueOut    = queueOut_r;
  assign bus.queueCount  = count_r;
endmodule
